// File: rtl/img_conv_host_if.sv
// Host byte-stream front end for the image-convolution core: parses commands,
// strobes the core and stages whole images in one shared pixel FIFO.
package img_conv_pkg;
  // Ordered so every legal opcode lies in 1..7; 0 is NOP and is rejected.
  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_SET_NROWS = 4'd1,
    OP_SET_NCOLS = 4'd2,
    OP_GET_NROWS = 4'd3,
    OP_GET_NCOLS = 4'd4,
    OP_IMG_RX    = 4'd5,
    OP_IMG_TX    = 4'd6,
    OP_CONV      = 4'd7
  } opcode_t;
endpackage

module img_conv_host_if
  import img_conv_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int TX_LAT = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       host_rx_valid,
  input  logic [7:0] host_rx_data,
  output logic       host_rx_ready,
  output logic       host_tx_valid,
  output logic [7:0] host_tx_data,
  input  logic       host_tx_ready,
  output logic       core_en,
  output opcode_t    core_op,
  output logic [7:0] core_din,
  input  logic [7:0] core_dout,
  input  logic       core_busy,
  output logic       err,
  output logic [3:0] dbg_state
);
  // Handshakes: a byte moves on any rising edge where valid && ready; the
  // response byte is registered and held while valid is high and ready is low.
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
  localparam logic [16:0] TX_LAT_W = 17'(TX_LAT);
  localparam logic [7:0]  RESP_OK  = 8'hA5;
  localparam logic [7:0]  RESP_ERR = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE, S_ARG, S_FILL, S_ISSUE, S_PUSH, S_CAPT, S_WAITB, S_DRAIN, S_RESP
  } state_t;

  state_t        state_q, state_d;
  opcode_t       op_q, op_d, core_op_q, core_op_d;
  logic [7:0]    arg_q, arg_d, nrows_q, nrows_d, ncols_q, ncols_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fifo_cnt_q, fifo_cnt_d;
  logic          rx_ready_q, rx_ready_d, tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d, core_din_q, core_din_d;
  logic          core_en_q, core_en_d, err_q, err_d;

  logic [7:0]    mem [DEPTH];
  logic          push, pop;
  logic [7:0]    wr_data;

  logic [15:0]   npix;
  logic [16:0]   npix_w, cap_first, cap_last;
  logic          rx_take, tx_free, fifo_empty, bad_npix, op_known;
  opcode_t       op_in;
  logic [7:0]    fifo_head;

  assign npix       = 16'(nrows_q) * 16'(ncols_q);
  assign npix_w     = {1'b0, npix};
  assign bad_npix   = (npix == 16'd0) || (npix_w > DEPTH_W);
  assign rx_take    = host_rx_valid && rx_ready_q;
  assign tx_free    = !tx_valid_q || host_tx_ready;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_head  = mem[rd_ptr_q];
  assign op_in      = opcode_t'(host_rx_data[3:0]);
  assign op_known   = (host_rx_data[7:4] == 4'h0) && (host_rx_data[3:0] != 4'h0) &&
                      (host_rx_data[3:0] <= 4'd7);

  // TX samples core_dout over TX_LAT..TX_LAT+npix-1 cycles after the strobe; GET only at 1.
  assign cap_first = (op_q == OP_IMG_TX) ? TX_LAT_W : 17'd1;
  assign cap_last  = (op_q == OP_IMG_TX) ? (TX_LAT_W + npix_w - 17'd1) : 17'd1;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    arg_d      = arg_q;
    nrows_d    = nrows_q;
    ncols_d    = ncols_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    core_en_d  = 1'b0;
    core_op_d  = core_op_q;
    core_din_d = core_din_q;
    err_d      = err_q;
    push       = 1'b0;
    pop        = 1'b0;
    wr_data    = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (rx_take) begin
          op_d  = op_in;
          arg_d = 8'h00;
          cnt_d = 17'd0;
          if (!op_known || ((op_in == OP_IMG_RX || op_in == OP_IMG_TX) && bad_npix)) begin
            err_d      = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = RESP_ERR;
            state_d    = S_RESP;
          end else if (op_in == OP_SET_NROWS || op_in == OP_SET_NCOLS) begin
            state_d = S_ARG;
          end else if (op_in == OP_IMG_RX) begin
            state_d = S_FILL;
          end else begin
            state_d    = S_ISSUE;
            core_en_d  = 1'b1;
            core_op_d  = op_in;
            core_din_d = 8'h00;
          end
        end
      end
      S_ARG: begin
        if (rx_take) begin
          arg_d      = host_rx_data;
          state_d    = S_ISSUE;
          core_en_d  = 1'b1;
          core_op_d  = op_q;
          core_din_d = host_rx_data;
        end
      end
      S_FILL: begin
        if (rx_take) begin
          push    = 1'b1;
          wr_data = host_rx_data;
          cnt_d   = cnt_q + 17'd1;
          if (cnt_q + 17'd1 == npix_w) begin
            state_d    = S_ISSUE;
            core_en_d  = 1'b1;
            core_op_d  = op_q;
            core_din_d = arg_q;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = 17'd1;
        case (op_q)
          OP_SET_NROWS: begin nrows_d = arg_q; cnt_d = 17'd0; state_d = S_WAITB; end
          OP_SET_NCOLS: begin ncols_d = arg_q; cnt_d = 17'd0; state_d = S_WAITB; end
          OP_CONV:      begin cnt_d = 17'd0; state_d = S_WAITB; end
          OP_IMG_RX: begin
            // Pixel 0 goes out on core_din in the cycle right after the strobe.
            pop        = 1'b1;
            core_din_d = fifo_head;
            state_d    = S_PUSH;
          end
          default: state_d = S_CAPT;
        endcase
      end
      S_PUSH: begin
        if (cnt_q == npix_w) begin
          cnt_d   = 17'd0;
          state_d = S_WAITB;
        end else begin
          pop        = 1'b1;
          core_din_d = fifo_head;
          cnt_d      = cnt_q + 17'd1;
        end
      end
      S_CAPT: begin
        cnt_d = cnt_q + 17'd1;
        if (cnt_q >= cap_first) begin
          push    = 1'b1;
          wr_data = core_dout;
        end
        if (cnt_q == cap_last) state_d = S_DRAIN;
      end
      S_WAITB: begin
        if (cnt_q < 17'd2) begin
          cnt_d = cnt_q + 17'd1;
        end else if (!core_busy) begin
          tx_valid_d = 1'b1;
          tx_data_d  = RESP_OK;
          state_d    = S_RESP;
        end
      end
      S_DRAIN: begin
        if (tx_free) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = fifo_head;
          end else if (op_q == OP_IMG_TX) begin
            tx_valid_d = 1'b1;
            tx_data_d  = RESP_OK;
            state_d    = S_RESP;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      S_RESP: begin
        if (tx_valid_q && host_tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + 1'b1;
    if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ARG) || (state_d == S_FILL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      arg_q      <= 8'h00;
      nrows_q    <= 8'd8;
      ncols_q    <= 8'd8;
      cnt_q      <= 17'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      core_en_q  <= 1'b0;
      core_op_q  <= OP_NOP;
      core_din_q <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      nrows_q    <= nrows_d;
      ncols_q    <= ncols_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      core_en_q  <= core_en_d;
      core_op_q  <= core_op_d;
      core_din_q <= core_din_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign host_rx_ready = rx_ready_q;
  assign host_tx_valid = tx_valid_q;
  assign host_tx_data  = tx_data_q;
  assign core_en       = core_en_q;
  assign core_op       = core_op_q;
  assign core_din      = core_din_q;
  assign err           = err_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_img_conv_host_if.sv
// Bench for img_conv_host_if: host-side drivers, a behavioural core model and
// scoreboards of expected response bytes and expected pixels.
module tb_img_conv_host_if;
  import img_conv_pkg::*;

  localparam int DEPTH  = 4096;
  localparam int TX_LAT = 2;

  logic       clk, rstn;
  logic       host_rx_valid, host_rx_ready, host_tx_valid, host_tx_ready;
  logic [7:0] host_rx_data, host_tx_data;
  logic       core_en, core_busy, err;
  opcode_t    core_op;
  logic [7:0] core_din, core_dout;
  logic [3:0] dbg_state;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pix_exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] en_din_q[$];
  opcode_t    en_op_q[$];
  int         en_count = 0;
  int         busy_fall_cyc = 0;
  logic [7:0] m_nrows, m_ncols;

  img_conv_host_if #(.DEPTH(DEPTH), .TX_LAT(TX_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data), .host_rx_ready(host_rx_ready),
    .host_tx_valid(host_tx_valid), .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready),
    .core_en(core_en), .core_op(core_op), .core_din(core_din),
    .core_dout(core_dout), .core_busy(core_busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run exceeded time limit (checks=%0d passed=%0d)", checks, passed);
    $fatal(1);
  end

  // ---------------- core model ----------------
  task automatic busy_for(input int n);
    core_busy = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    core_busy = 1'b0;
    busy_fall_cyc = cyc;
  endtask

  initial begin : core_model
    opcode_t    op;
    logic [7:0] din;
    int         npix;
    core_dout = 8'h00;
    core_busy = 1'b0;
    m_nrows   = 8'd8;
    m_ncols   = 8'd8;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_nrows = 8'd8; m_ncols = 8'd8; core_busy = 1'b0; core_dout = 8'h00;
      end else if (core_en === 1'b1) begin
        op  = core_op;
        din = core_din;
        en_count++;
        en_op_q.push_back(op);
        en_din_q.push_back(din);
        npix = int'(m_nrows) * int'(m_ncols);
        @(posedge clk);
        #1;
        case (op)
          OP_SET_NROWS: begin m_nrows = din; busy_for(3); end
          OP_SET_NCOLS: begin m_ncols = din; busy_for(3); end
          OP_GET_NROWS: core_dout = m_nrows;
          OP_GET_NCOLS: core_dout = m_ncols;
          OP_CONV:      busy_for(50);
          OP_IMG_RX: begin
            core_busy = 1'b1;
            for (int k = 0; k < npix; k++) begin
              cap_q.push_back(core_din);
              @(posedge clk);
              #1;
            end
            busy_for(4);
          end
          OP_IMG_TX: begin
            repeat (TX_LAT - 1) begin @(posedge clk); #1; end
            for (int k = 0; k < npix; k++) begin
              core_dout = 8'h20 + 8'(k);
              @(posedge clk);
              #1;
            end
            core_dout = 8'h00;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(0, max_gap)) step();
    host_rx_valid = 1'b1;
    host_rx_data  = b;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (host_rx_ready === 1'b1) ok = 1'b1;
      step();
    end
    host_rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL send_timeout: byte %02h not accepted within 500 cycles", b);
    end
  endtask

  task automatic recv_byte(input bit rand_rdy, output logic [7:0] b);
    bit ok;
    ok = 1'b0;
    b  = 8'hxx;
    for (int i = 0; i < 1000 && !ok; i++) begin
      host_tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (host_tx_valid === 1'b1 && host_tx_ready) begin
        b  = host_tx_data;
        ok = 1'b1;
      end
      step();
    end
    host_tx_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({host_rx_ready, host_tx_valid, host_tx_data, core_en, core_din, err} !== 20'h0)
      $display("FAIL reset_outputs: got rx_rdy=%b tx_v=%b tx_d=%02h en=%b din=%02h err=%b, want all 0",
               host_rx_ready, host_tx_valid, host_tx_data, core_en, core_din, err);
    else passed++;
    checks++;
    if (core_op !== OP_NOP) $display("FAIL reset_core_op: got %0d want %0d", core_op, OP_NOP);
    else passed++;
    step();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (host_rx_ready !== 1'b0) $display("FAIL rx_ready_early: got %b want 0", host_rx_ready);
    else passed++;
    @(negedge clk);
    checks++;
    if (host_rx_ready !== 1'b1) $display("FAIL rx_ready_rise: got %b want 1", host_rx_ready);
    else passed++;
    step();
  endtask

  task automatic test_param_roundtrip();
    logic [7:0] b, e;
    int en0;
    en0 = en_count;
    en_din_q.delete();
    exp_q.push_back(8'hA5);
    send_byte(8'(OP_SET_NROWS), 2);
    send_byte(8'h04, 2);
    recv_byte(1'b0, b);
    e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL set_nrows_resp: got %02h want %02h", b, e); else passed++;
    exp_q.push_back(8'h04);
    send_byte(8'(OP_GET_NROWS), 2);
    recv_byte(1'b0, b);
    e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL get_nrows_resp: got %02h want %02h", b, e); else passed++;
    checks++;
    if (en_count - en0 != 2) $display("FAIL roundtrip_en_count: got %0d want 2", en_count - en0);
    else passed++;
    checks++;
    if (en_din_q.size() == 0 || en_din_q[0] !== 8'h04)
      $display("FAIL roundtrip_set_din: got %02h want 04", (en_din_q.size() > 0) ? en_din_q[0] : 8'hxx);
    else passed++;
  endtask

  task automatic test_image_load();
    logic [7:0] b, e, c;
    int en0;
    exp_q.push_back(8'hA5);
    send_byte(8'(OP_SET_NROWS), 1); send_byte(8'd2, 1);
    recv_byte(1'b0, b); e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL load_set_rows: got %02h want %02h", b, e); else passed++;
    exp_q.push_back(8'hA5);
    send_byte(8'(OP_SET_NCOLS), 1); send_byte(8'd3, 1);
    recv_byte(1'b0, b); e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL load_set_cols: got %02h want %02h", b, e); else passed++;
    en0 = en_count;
    en_op_q.delete();
    cap_q.delete();
    send_byte(8'(OP_IMG_RX), 3);
    for (int k = 0; k < 6; k++) begin
      pix_exp_q.push_back(8'h10 + 8'(k));
      send_byte(8'h10 + 8'(k), 4);
    end
    exp_q.push_back(8'hA5);
    recv_byte(1'b0, b); e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL load_resp: got %02h want %02h", b, e); else passed++;
    checks++;
    if (en_count - en0 != 1 || en_op_q.size() == 0 || en_op_q[0] !== OP_IMG_RX)
      $display("FAIL load_strobe: got %0d strobes want 1 with OP_IMG_RX", en_count - en0);
    else passed++;
    for (int k = 0; k < 6; k++) begin
      e = pix_exp_q.pop_front();
      c = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
      checks++;
      if (c !== e) $display("FAIL load_pixel_%0d: got %02h want %02h", k, c, e); else passed++;
    end
  endtask

  task automatic test_image_readback();
    logic [7:0] b, e;
    for (int k = 0; k < 6; k++) exp_q.push_back(8'h20 + 8'(k));
    exp_q.push_back(8'hA5);
    send_byte(8'(OP_IMG_TX), 2);
    for (int k = 0; k < 7; k++) begin
      recv_byte(1'b1, b);
      e = exp_q.pop_front();
      checks++;
      if (b !== e) $display("FAIL readback_byte_%0d: got %02h want %02h", k, b, e); else passed++;
    end
  endtask

  task automatic test_conv();
    logic [7:0] b, e;
    int ready_seen, tx_cyc;
    ready_seen = 0;
    tx_cyc = -1;
    busy_fall_cyc = 32'h7fffffff;
    exp_q.push_back(8'hA5);
    send_byte(8'(OP_CONV), 0);
    for (int i = 0; i < 300 && tx_cyc < 0; i++) begin
      @(negedge clk);
      if (host_tx_valid === 1'b1) tx_cyc = cyc;
      if (host_rx_ready !== 1'b0) ready_seen++;
      step();
    end
    recv_byte(1'b0, b);
    e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL conv_resp: got %02h want %02h", b, e); else passed++;
    checks++;
    if (tx_cyc < 0 || tx_cyc <= busy_fall_cyc)
      $display("FAIL conv_resp_timing: resp cycle %0d, busy fell at cycle %0d", tx_cyc, busy_fall_cyc);
    else passed++;
    checks++;
    if (ready_seen != 0) $display("FAIL conv_rx_ready: got %0d ready cycles want 0", ready_seen);
    else passed++;
  endtask

  task automatic test_errors();
    logic [7:0] b, e;
    int en0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'hA5);
      send_byte((i == 0) ? 8'(OP_SET_NROWS) : 8'(OP_SET_NCOLS), 1);
      send_byte(8'd100, 1);
      recv_byte(1'b0, b); e = exp_q.pop_front();
      checks++;
      if (b !== e) $display("FAIL err_set_%0d: got %02h want %02h", i, b, e); else passed++;
    end
    en0 = en_count;
    exp_q.push_back(8'hEE);
    send_byte(8'(OP_IMG_RX), 1);
    recv_byte(1'b0, b); e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL err_rx_resp: got %02h want %02h", b, e); else passed++;
    checks++;
    if (err !== 1'b1) $display("FAIL err_flag_set: got %b want 1", err); else passed++;
    exp_q.push_back(8'hEE);
    send_byte(8'hFF, 1);
    recv_byte(1'b0, b); e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL err_unknown_resp: got %02h want %02h", b, e); else passed++;
    checks++;
    if (err !== 1'b1) $display("FAIL err_flag_sticky: got %b want 1", err); else passed++;
    checks++;
    if (en_count != en0) $display("FAIL err_no_strobe: got %0d strobes want 0", en_count - en0);
    else passed++;
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] b, e;
    int en0;
    exp_q.push_back(8'hA5);
    send_byte(8'(OP_SET_NROWS), 0); send_byte(8'd2, 0);
    recv_byte(1'b0, b); e = exp_q.pop_front();
    exp_q.push_back(8'hA5);
    send_byte(8'(OP_SET_NCOLS), 0); send_byte(8'd3, 0);
    recv_byte(1'b0, b); e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL rst_setup: got %02h want %02h", b, e); else passed++;
    en0 = en_count;
    send_byte(8'(OP_IMG_RX), 0);
    for (int k = 0; k < 3; k++) send_byte(8'h30 + 8'(k), 1);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({host_rx_ready, host_tx_valid, host_tx_data, core_en, core_din, err} !== 20'h0 ||
        core_op !== OP_NOP)
      $display("FAIL rst_async_outputs: got rx_rdy=%b tx_v=%b tx_d=%02h en=%b op=%0d din=%02h err=%b",
               host_rx_ready, host_tx_valid, host_tx_data, core_en, core_op, core_din, err);
    else passed++;
    repeat (2) step();
    rstn = 1'b1;
    repeat (10) step();
    checks++;
    if (en_count != en0) $display("FAIL rst_no_strobe: got %0d strobes want 0", en_count - en0);
    else passed++;
    exp_q.push_back(8'd8);
    send_byte(8'(OP_GET_NCOLS), 0);
    recv_byte(1'b0, b); e = exp_q.pop_front();
    checks++;
    if (b !== e) $display("FAIL rst_get_ncols: got %02h want %02h", b, e); else passed++;
  endtask

  initial begin : main
    rstn          = 1'b0;
    host_rx_valid = 1'b0;
    host_rx_data  = 8'h00;
    host_tx_ready = 1'b0;
    test_reset();
    test_param_roundtrip();
    test_image_load();
    test_image_readback();
    test_conv();
    test_errors();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/img_conv_host_if.md
# img_conv_host_if

Byte-stream front end for the image-convolution core. It sits between the host link (UART/SPI byte streams with valid/ready) and the core's `en`/`op`/`din`/`dout`/`busy` port. It parses host commands and issues single-cycle `en` pulses to the core. Because the core moves pixels at one byte per clock with no flow control, a pixel FIFO stages each whole image, so a slow host never under-runs or over-runs the core.

## Interface
Parameters:
- `DEPTH`, 4096: pixel FIFO depth, power of two; largest image accepted, as `nrows*ncols`.
- `TX_LAT`, 2: cycles from the core `en` pulse of `OP_IMG_TX` to the first valid pixel on `core_dout`.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `host_rx_valid`  in  1  host byte valid.
- `host_rx_data`  in  8  host byte.
- `host_rx_ready`  out  1  block accepts the host byte this cycle.
- `host_tx_valid`  out  1  response byte valid.
- `host_tx_data`  out  8  response byte.
- `host_tx_ready`  in  1  host accepts the response byte.
- `core_en`  out  1  one-cycle command strobe to the core.
- `core_op`  out  `opcode_t`  core opcode; meaningful while `core_en`=1.
- `core_din`  out  8  argument or pixel byte to the core.
- `core_dout`  in  8  core result or pixel byte.
- `core_busy`  in  1  core busy.
- `err`  out  1  sticky error flag; cleared only by reset.

## Operation
- **Command format.** Byte 0 is the opcode, the `opcode_t` value zero-extended to 8 bits.
  - `OP_SET_*` takes one argument byte.
  - `OP_IMG_RX` is followed by exactly `nrows*ncols` pixel bytes.
  - All other opcodes take no further bytes.
- **Shadow registers.** `nrows`/`ncols` reset to 8 and are updated when the block issues `OP_SET_NROWS`/`OP_SET_NCOLS`. `npix = nrows*ncols` is 16-bit.
- **Responses.**
  - `OP_GET_*` returns the captured `core_dout`.
  - `OP_SET_*`, `OP_CONV` and `OP_IMG_RX` return `0xA5` after the core finishes.
  - `OP_IMG_TX` returns `npix` pixels, row-major in core order, then `0xA5`.
  - Unknown opcode, `OP_NOP`, `npix==0` or `npix>DEPTH` on RX/TX: the block returns `0xEE`, sets `err`, and does not strobe the core. For a rejected RX, the following pixel bytes are parsed as new commands; the host must resync.
- **FSM states:** IDLE, ARG, FILL, ISSUE, PUSH, CAPT, WAITB, DRAIN, RESP.
- **Transitions.**
  - IDLE: on an accepted opcode byte, go to ARG (`SET_*`), FILL (`IMG_RX`), RESP (error), or ISSUE (all others).
  - ARG: accept one byte into the argument register, then go to ISSUE.
  - FILL: accept bytes into the FIFO until `npix` have been stored, then go to ISSUE.
  - ISSUE: assert `core_en` for exactly one cycle, with `core_op` and `core_din` = argument. Then go to PUSH (RX), CAPT (TX, GET), or WAITB (SET, CONV).
  - PUSH: pop one FIFO byte per cycle onto `core_din`, for `npix` consecutive cycles, then go to WAITB.
  - CAPT: write `core_dout` into the FIFO, `npix` bytes for TX or 1 byte for GET, then go to DRAIN.
  - WAITB: ignore `core_busy` for 2 cycles, then wait for `core_busy==0`, then go to RESP.
  - DRAIN: send FIFO bytes to the host, then go to RESP (TX) or IDLE (GET).
  - RESP: send the status byte, then go to IDLE.
- `host_rx_ready`=1 only in IDLE, ARG and FILL.
- The FIFO is a single dual-pointer buffer shared by both directions and is empty in IDLE. Pointers wrap modulo `DEPTH`. `npix==DEPTH` is legal and fills the FIFO exactly.

## Timing
- **Reset values:** `host_rx_ready`=0, `host_tx_valid`=0, `host_tx_data`=0, `core_en`=0, `core_op`=`OP_NOP`, `core_din`=0, `err`=0. The FSM resets to IDLE, the FIFO to empty, and the shadow registers to 8/8. `host_rx_ready` rises the first cycle after reset deasserts.
- **Byte handshakes:** a byte transfers on any edge with valid&&ready. `host_tx_data` is held stable while `host_tx_valid`=1 and `host_tx_ready`=0.
- **Core strobe timing:** `core_en` rises the cycle after the final command/argument/pixel byte is accepted. `core_op` and `core_din` are registered and valid in the same cycle as `core_en`.
- **RX pixel timing:** pixel 0 is on `core_din` in the cycle after the `core_en` cycle, and pixel k in cycle k+1. The stream has no gaps.
- **TX capture timing:** `core_dout` is sampled in cycles `TX_LAT`..`TX_LAT+npix-1` after the `core_en` cycle.
- **GET capture timing:** `core_dout` is sampled 1 cycle after the `core_en` cycle.
- **Stale data:** new host input is not accepted before RESP completes, so a stale `core_dout` is never returned.
- **Asynchronous reset mid-transfer:** the block returns to reset values immediately. A partially filled FIFO is discarded and no further `core_en` pulse follows.
- **Host throttling:** deasserting `host_tx_ready` in DRAIN stalls only DRAIN; the core is already idle.

## Test plan
- **Parameter round-trip.** Send `SET_NROWS 0x04`, then `GET_NROWS`. Required: `0xA5`, then `0x04`. Exactly two `core_en` pulses occur, and `core_din`=0x04 on the first.
- **Image load.** `SET_NROWS 2`, `SET_NCOLS 3`, then `IMG_RX` with bytes 0x10..0x15 sent with random host gaps. Required: one `core_en` with `OP_IMG_RX`; `core_din` carries 0x10..0x15 on six consecutive cycles starting 1 cycle after `core_en`; response `0xA5` after `core_busy` falls.
- **Image readback.** `IMG_TX` on a 2x3 image, with a core model driving 0x20..0x25 starting `TX_LAT` cycles after `en`, and `host_tx_ready` toggled at random. Required: host receives 0x20..0x25, then `0xA5`.
- **Convolution.** `CONV` with the core holding `busy` high for 50 cycles. Required: `0xA5` is emitted no earlier than the cycle after `busy` falls; `host_rx_ready`=0 throughout.
- **Errors.** Set 100x100 with `DEPTH`=4096, then send `IMG_RX`. Required: `0xEE`, `err`=1, no `core_en`. Then send an unknown opcode 0xFF. Required: `0xEE`, and `err` stays 1.
- **Reset mid-FILL.** Assert `rstn`=0 after 3 of 6 pixel bytes. Required: all outputs at reset values. A subsequent `GET_NCOLS` returns 8.
